// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// serial_subtractor_pkg : shared FSM encoding and default width  (rev 1.0)
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/hierarchy_full_subractor.sv
// ============================================================================
// hierarchy_full_subractor : one-bit full subtractor a - b - bin  (rev 1.0)
// ============================================================================
`default_nettype none

module hierarchy_full_subractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial LSB-first subtractor, one bit per clock
// rev 1.0
// ============================================================================
`default_nettype none

module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic             borrow;
   logic             cell_d;
   logic             cell_b;
   logic             accept;
   logic             last_bit;

   assign accept   = (state == ST_IDLE) && start;
   assign last_bit = (state == ST_RUN) && (cnt == LAST_CNT);
   // res_sh keeps only the W-1 bits produced so far; the final bit completes it
   assign res_next = {cell_d, res_sh};

   hierarchy_full_subractor u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (borrow),
      .d    (cell_d),
      .bout (cell_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start)    state_nxt = ST_RUN;
         ST_RUN:  if (last_bit) state_nxt = ST_DONE;
         ST_DONE:               state_nxt = ST_IDLE;
         default:               state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         ST_RUN:  busy = 1'b1;
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         borrow <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
      end else if (accept) begin
         cnt    <= '0;
         a_sh   <= a;
         b_sh   <= b;
         borrow <= bin;
      end else if (state == ST_RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         borrow <= cell_b;
         res_sh <= res_next[WIDTH-1:1];
         if (last_bit) begin
            diff <= res_next;
            bout <= cell_b;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : directed and random checks of serial_subtractor
// rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        bin = 1'b0;
   logic        busy;
   logic        done;
   logic [7:0]  diff;
   logic        bout;

   logic        start16 = 1'b0;
   logic [15:0] a16 = '0;
   logic [15:0] b16 = '0;
   logic        bin16 = 1'b0;
   logic        busy16;
   logic        done16;
   logic [15:0] diff16;
   logic        bout16;

   int total  = 0;
   int passed = 0;
   int failed = 0;
   int cycles = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycles <= cycles + 1;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout)
   );

   serial_subtractor #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
      .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full operation on the 8-bit instance, expected value from a 9-bit model
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        input string tag);
      logic [8:0] m;
      int         cyc;
      bit         seen;
      m = {1'b0, ta} - {1'b0, tb} - {8'd0, tbin};
      a = ta; b = tb; bin = tbin; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      seen = 1'b0;
      while (!seen && cyc < 14) begin
         tick();
         cyc++;
         if (done) seen = 1'b1;
      end
      chk({tag, " latency"}, cyc, 9);
      chk({tag, " diff"}, diff, m[7:0]);
      chk({tag, " bout"}, bout, m[8]);
      tick();
      chk({tag, " idle"}, {busy, done}, 2'b00);
   endtask

   task automatic do_op16(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                          input string tag);
      logic [16:0] m;
      int          cyc;
      bit          seen;
      m = {1'b0, ta} - {1'b0, tb} - {16'd0, tbin};
      a16 = ta; b16 = tb; bin16 = tbin; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      cyc = 1;
      seen = 1'b0;
      while (!seen && cyc < 22) begin
         tick();
         cyc++;
         if (done16) seen = 1'b1;
      end
      chk({tag, " latency"}, cyc, 17);
      chk({tag, " diff"}, diff16, m[15:0]);
      chk({tag, " bout"}, bout16, m[16]);
      tick();
   endtask

   initial begin
      logic [8:0] exp_q [3];
      logic [7:0] ra, rb;
      logic       rbin;
      int         last_done;
      bit         seen;
      int         k;

      // Reset state
      tick();
      chk("reset outputs", {busy, done, diff, bout}, 11'd0);
      chk("reset outputs w16", {busy16, done16, diff16, bout16}, 19'd0);
      rst = 1'b0;

      // Detailed timing of 0x5A - 0x3C
      a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         chk($sformatf("timing busy c%0d", c), busy, 1'b1);
         chk($sformatf("timing done c%0d", c), done, (c == 9) ? 1'b1 : 1'b0);
         if (c < 9) chk($sformatf("timing diff hold c%0d", c), diff, 8'h00);
         if (c < 9) tick();
      end
      chk("5a-3c diff", diff, 8'h1E);
      chk("5a-3c bout", bout, 1'b0);
      tick();
      chk("5a-3c idle busy", busy, 1'b0);
      chk("5a-3c diff held", diff, 8'h1E);

      // Boundary vectors
      do_op(8'h00, 8'h01, 1'b0, "00-01");
      do_op(8'hFF, 8'hFF, 1'b1, "ff-ff-1");
      do_op(8'h80, 8'h00, 1'b1, "80-00-1");
      do_op(8'hFF, 8'h00, 1'b0, "ff-00");
      do_op(8'h00, 8'h00, 1'b1, "00-00-1");
      do_op(8'h7F, 8'h80, 1'b0, "7f-80");
      do_op(8'h01, 8'h01, 1'b0, "01-01");

      // start re-pulsed during RUN must be ignored
      a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      a = 8'hAA; start = 1'b1;
      tick();
      start = 1'b0; a = 8'h10;
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
         tick();
         if (done) seen = 1'b1;
      end
      chk("ignore-start done", seen, 1'b1);
      chk("ignore-start diff", diff, 8'h0F);
      chk("ignore-start bout", bout, 1'b0);
      tick();
      chk("ignore-start idle1", busy, 1'b0);
      tick();
      chk("ignore-start idle2", busy, 1'b0);

      // Asynchronous reset during RUN
      a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      #3 rst = 1'b1;
      #1;
      chk("async rst outputs", {busy, done, diff, bout}, 11'd0);
      tick();
      #3 rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 14; c++) begin
         tick();
         if (done || busy) seen = 1'b1;
      end
      chk("no activity after rst", seen, 1'b0);
      do_op(8'hC3, 8'h3C, 1'b1, "post-rst");

      // Back-to-back with start held high
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      a = ra; b = rb; bin = rbin; start = 1'b1;
      exp_q[0] = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      last_done = 0;
      k = 0;
      for (int c = 0; c < 60 && k < 3; c++) begin
         tick();
         if (done) begin
            chk($sformatf("b2b%0d diff", k), diff, exp_q[k][7:0]);
            chk($sformatf("b2b%0d bout", k), bout, exp_q[k][8]);
            if (k > 0) chk($sformatf("b2b%0d spacing", k), cycles - last_done, 10);
            last_done = cycles;
            if (k < 2) begin
               ra = 8'($urandom_range(0, 255));
               rb = 8'($urandom_range(0, 255));
               rbin = 1'($urandom_range(0, 1));
               a = ra; b = rb; bin = rbin;
               exp_q[k+1] = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            end else begin
               start = 1'b0;
            end
            k++;
         end
      end
      chk("b2b count", k, 3);
      start = 1'b0;
      tick();
      tick();
      chk("b2b stop", busy, 1'b0);

      // Random regression on both widths
      for (int i = 0; i < 200; i++) begin
         do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), $sformatf("rnd8_%0d", i));
      end
      do_op16(16'h0000, 16'h0001, 1'b0, "w16 00-01");
      do_op16(16'hFFFF, 16'hFFFF, 1'b1, "w16 ff-ff-1");
      do_op16(16'h8000, 16'h0000, 1'b1, "w16 80-00-1");
      for (int i = 0; i < 100; i++) begin
         do_op16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)), $sformatf("rnd16_%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
